// File: rtl/serial_frame_deser.sv
// rtl/serial_frame_deser.sv - sync-word hunting serial-to-parallel frame deserialiser
module serial_frame_deser #(
    parameter int                SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011,
    parameter int                DATA_W   = 8,
    parameter int                CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_in,
    input  logic              en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              sync_lock,
    output logic              sync_err,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int MAX_W = (DATA_W > SYNC_W) ? DATA_W : SYNC_W;
    localparam int CW    = $clog2(MAX_W + 1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SYNC_W-1:0]   hunt_q, hunt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                data_valid_q, data_valid_d;
    logic                sync_lock_q, sync_lock_d;
    logic                sync_err_q, sync_err_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;

    logic [SYNC_W-1:0]   hunt_shift;
    logic [DATA_W-1:0]   data_shift;

    assign hunt_shift = {hunt_q[SYNC_W-2:0], d_in};
    assign data_shift = {data_q[DATA_W-2:0], d_in};

    always_comb begin
        state_d      = state_q;
        hunt_d       = hunt_q;
        data_d       = data_q;
        bit_cnt_d    = bit_cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        sync_err_d   = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        if (en) begin
            case (state_q)
                HUNT: begin
                    hunt_d = hunt_shift;
                    if (hunt_shift == SYNC_PAT) begin
                        state_d   = SHIFT;
                        bit_cnt_d = '0;
                    end
                end
                SHIFT: begin
                    data_d    = data_shift;
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(DATA_W - 1)) begin
                        data_out_d   = data_shift;
                        data_valid_d = 1'b1;
                        if (frame_cnt_q != {CNT_W{1'b1}}) begin
                            frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        end
                        bit_cnt_d = '0;
                        state_d   = CHECK;
                    end
                end
                CHECK: begin
                    // The hunt register doubles as the inter-frame sync collector.
                    hunt_d    = hunt_shift;
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(SYNC_W - 1)) begin
                        bit_cnt_d = '0;
                        if (hunt_shift == SYNC_PAT) begin
                            state_d = SHIFT;
                        end else begin
                            state_d    = HUNT;
                            sync_err_d = 1'b1;
                            hunt_d     = '0;
                        end
                    end
                end
                default: begin
                    state_d   = HUNT;
                    hunt_d    = '0;
                    bit_cnt_d = '0;
                end
            endcase
        end

        sync_lock_d = (state_d != HUNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            hunt_q       <= '0;
            data_q       <= '0;
            bit_cnt_q    <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            sync_lock_q  <= 1'b0;
            sync_err_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            hunt_q       <= hunt_d;
            data_q       <= data_d;
            bit_cnt_q    <= bit_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            sync_lock_q  <= sync_lock_d;
            sync_err_q   <= sync_err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign sync_lock  = sync_lock_q;
    assign sync_err   = sync_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_serial_frame_deser.sv
// tb/tb_serial_frame_deser.sv - randomized self-checking bench for serial_frame_deser
module tb_serial_frame_deser;

    localparam logic [3:0] PAT = 4'b1011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       d_in = 1'b0;
    logic       en = 1'b0;
    logic [7:0] data_out, data_out2;
    logic       data_valid, data_valid2;
    logic       sync_lock, sync_lock2;
    logic       sync_err, sync_err2;
    logic [7:0] frame_cnt;
    logic [1:0] frame_cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_frame_deser #(.SYNC_W(4), .SYNC_PAT(4'b1011), .DATA_W(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .en(en),
        .data_out(data_out), .data_valid(data_valid), .sync_lock(sync_lock),
        .sync_err(sync_err), .frame_cnt(frame_cnt)
    );

    serial_frame_deser #(.SYNC_W(4), .SYNC_PAT(4'b1011), .DATA_W(8), .CNT_W(2)) u_dut_c2 (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .en(en),
        .data_out(data_out2), .data_valid(data_valid2), .sync_lock(sync_lock2),
        .sync_err(sync_err2), .frame_cnt(frame_cnt2)
    );

    // Reference model: framing expressed as bit queues gathered per phase.
    bit   m_locked;
    bit   m_in_payload;
    bit   win[$];
    bit   coll[$];
    logic [7:0] exp_data;
    logic exp_valid, exp_err;
    int   exp_cnt8, exp_cnt2;

    function automatic int pack(input bit q[$]);
        int v = 0;
        foreach (q[i]) v = (v << 1) | int'(q[i]);
        return v;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_in_payload = 0;
        win.delete(); coll.delete();
        exp_data = 8'h00; exp_valid = 0; exp_err = 0;
        exp_cnt8 = 0; exp_cnt2 = 0;
    endtask

    task automatic model_bit(input bit b);
        if (!m_locked) begin
            win.push_back(b);
            if (win.size() > 4) void'(win.pop_front());
            if (win.size() == 4 && pack(win) == int'(PAT)) begin
                m_locked = 1; m_in_payload = 1; coll.delete();
            end
        end else if (m_in_payload) begin
            coll.push_back(b);
            if (coll.size() == 8) begin
                exp_data  = 8'(pack(coll));
                exp_valid = 1;
                if (exp_cnt8 < 255) exp_cnt8++;
                if (exp_cnt2 < 3) exp_cnt2++;
                m_in_payload = 0; coll.delete();
            end
        end else begin
            coll.push_back(b);
            if (coll.size() == 4) begin
                if (pack(coll) == int'(PAT)) m_in_payload = 1;
                else begin
                    m_locked = 0; exp_err = 1; win.delete();
                end
                coll.delete();
            end
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input logic b, input logic e);
        @(negedge clk);
        d_in = b; en = e;
        @(posedge clk);
        exp_valid = 0; exp_err = 0;
        if (!rst_n) model_reset();
        else if (e) model_bit(b);
        #1;
        check_eq("data_out",   32'(data_out),   32'(exp_data));
        check_eq("data_valid", 32'(data_valid), 32'(exp_valid));
        check_eq("sync_lock",  32'(sync_lock),  32'(m_locked));
        check_eq("sync_err",   32'(sync_err),   32'(exp_err));
        check_eq("frame_cnt",  32'(frame_cnt),  32'(exp_cnt8));
        check_eq("c2_frame_cnt",  32'(frame_cnt2),  32'(exp_cnt2));
        check_eq("c2_data_valid", 32'(data_valid2), 32'(exp_valid));
    endtask

    task automatic send(input logic [31:0] v, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            repeat (gap) tick(1'($urandom), 1'b0);
            tick(v[i], 1'b1);
        end
    endtask

    task automatic set_reset(input logic r);
        @(negedge clk);
        rst_n = r;
    endtask

    initial begin
        model_reset();
        // Reset held while inputs toggle.
        repeat (6) tick(1'($urandom), 1'($urandom));
        set_reset(1'b1);
        repeat (3) tick(1'b0, 1'b1);

        // Two good frames, then a broken sync word.
        send(32'hB, 4, 0);
        check_eq("t2_lock", 32'(sync_lock), 32'd1);
        send(32'hA5, 8, 0);
        check_eq("t2_data", 32'(data_out), 32'hA5);
        check_eq("t2_cnt", 32'(frame_cnt), 32'd1);
        send(32'hB3C, 12, 0);
        check_eq("t3_data", 32'(data_out), 32'h3C);
        check_eq("t3_cnt", 32'(frame_cnt), 32'd2);
        send(32'h9, 4, 0);
        check_eq("t4_err", 32'(sync_err), 32'd1);
        check_eq("t4_lock", 32'(sync_lock), 32'd0);
        send(32'h00, 8, 0);
        check_eq("t4_hold", 32'(data_out), 32'h3C);

        // Sparse strobes, then an overlapping sync after a forced mismatch.
        send(32'hBC3, 12, 2);
        check_eq("t5_data", 32'(data_out), 32'hC3);
        send(32'h0, 4, 2);
        send(32'h2B5A, 14, 2);
        check_eq("t5_overlap", 32'(data_out), 32'h5A);

        // Saturation on the 2-bit counter, then reset mid-frame.
        set_reset(1'b0);
        tick(1'b0, 1'b0);
        set_reset(1'b1);
        for (int f = 1; f <= 5; f++) begin
            send({20'h0, PAT, 8'($urandom)}, 12, 0);
            check_eq("t6_c2_cnt", 32'(frame_cnt2), (f < 3) ? 32'(f) : 32'd3);
        end
        send({24'h0, PAT, 4'($urandom)}, 8, 0);
        set_reset(1'b0);
        repeat (4) tick(1'($urandom), 1'b1);
        check_eq("t6_rst_cnt", 32'(frame_cnt2), 32'd0);
        set_reset(1'b1);

        // Random traffic against the model.
        repeat (400) tick(1'($urandom), ($urandom % 3) != 0);
        for (int k = 0; k < 20; k++) begin
            send({20'h0, PAT, 8'($urandom)}, 12, int'($urandom % 3));
            if (($urandom % 4) == 0) send(32'($urandom % 16), 4, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
